// File: rtl/psum_rbuffer_if.sv
// psum_rbuffer_if: Output-Memory read port and OutputStage pop port
// of the partial-sum read buffer.
interface psum_rbuffer_if #(
    parameter int DW = 64,
    parameter int AW = 4
);
    logic          RE_rb;
    logic [AW-1:0] RADDR_rb;
    logic [DW-1:0] RData_om;
    logic          POP_om;
    logic [AW-1:0] ODST_om;
    logic [DW-1:0] PSUM_rb;
    logic          PVALID_rb;

    modport master (
        output RE_rb, RADDR_rb, PSUM_rb, PVALID_rb,
        input  RData_om, POP_om, ODST_om
    );

    modport slave (
        input  RE_rb, RADDR_rb, PSUM_rb, PVALID_rb,
        output RData_om, POP_om, ODST_om
    );
endinterface

// File: rtl/psum_rbuffer.sv
// psum_rbuffer: fetches prior partial-sum rows from Output-Memory into a small
// bank and pops them to OutputStage. RBUF_ADDR_CHECK_EN adds ADDR_MISMATCH.
module psum_rbuffer #(
    parameter int DW    = 64,
    parameter int AW    = 4,
    parameter int DEPTH = 4
) (
    input  logic          CLK,
    input  logic          RSTN,
    input  logic          CLR_DP,
    input  logic [2:0]    ROW_TOTAL,
    input  logic          LOAD_REQ,
    input  logic [AW-1:0] BASE_ADDR,
    output logic          FETCH_DONE,
    output logic          DRAIN_DONE,
    output logic          UNDERFLOW,
    output logic          BUSY,
`ifdef RBUF_ADDR_CHECK_EN
    output logic          ADDR_MISMATCH,
`endif
    psum_rbuffer_if.master bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT, S_HOLD} state_t;
    state_t state, state_nx;

    logic [DW-1:0] bank [DEPTH];
    logic [CW-1:0] n_lat, n_in, rptr, wptr, cnt;
    logic [IW-1:0] widx, cidx;
    logic [AW-1:0] base_lat;
    logic          re_d, zero_pend, issue, pop_ok;

    assign n_in = (32'(ROW_TOTAL) > 32'(DEPTH)) ? CW'(DEPTH) : CW'(ROW_TOTAL);
    assign widx = wptr[IW-1:0];
    assign cidx = cnt[IW-1:0];

    assign BUSY         = (state != S_IDLE);
    assign bus.RE_rb    = issue;
    assign bus.RADDR_rb = issue ? base_lat + AW'(rptr) : '0;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN)
            state <= S_IDLE;
        else if (CLR_DP)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        issue    = 1'b0;
        pop_ok   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (LOAD_REQ && n_in != '0)
                    state_nx = S_FETCH;
            end
            S_FETCH: begin
                issue = 1'b1;
                if (rptr == n_lat - CW'(1))
                    state_nx = S_WAIT;
            end
            S_WAIT: state_nx = S_HOLD;
            S_HOLD: begin
                if (bus.POP_om) begin
                    pop_ok = 1'b1;
                    if (cnt == n_lat - CW'(1))
                        state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN || CLR_DP) begin
            for (int i = 0; i < DEPTH; i++)
                bank[i] <= '0;
            n_lat         <= '0;
            base_lat      <= '0;
            rptr          <= '0;
            wptr          <= '0;
            cnt           <= '0;
            re_d          <= 1'b0;
            zero_pend     <= 1'b0;
            FETCH_DONE    <= 1'b0;
            DRAIN_DONE    <= 1'b0;
            UNDERFLOW     <= 1'b0;
            bus.PSUM_rb   <= '0;
            bus.PVALID_rb <= 1'b0;
        end else begin
            FETCH_DONE    <= 1'b0;
            DRAIN_DONE    <= zero_pend;
            UNDERFLOW     <= 1'b0;
            bus.PVALID_rb <= 1'b0;
            zero_pend     <= 1'b0;
            re_d          <= issue;
            if (state == S_IDLE && LOAD_REQ) begin
                n_lat    <= n_in;
                base_lat <= BASE_ADDR;
                rptr     <= '0;
                wptr     <= '0;
                cnt      <= '0;
                if (n_in == '0) begin
                    FETCH_DONE <= 1'b1;
                    zero_pend  <= 1'b1;
                end
            end
            if (issue)
                rptr <= rptr + CW'(1);
            // read data lands one cycle after its issue
            if (re_d) begin
                bank[widx] <= bus.RData_om;
                wptr       <= wptr + CW'(1);
            end
            if (state == S_WAIT) begin
                FETCH_DONE <= 1'b1;
                cnt        <= '0;
            end
            if (pop_ok) begin
                bus.PSUM_rb   <= bank[cidx];
                bus.PVALID_rb <= 1'b1;
                cnt           <= cnt + CW'(1);
                if (cnt == n_lat - CW'(1))
                    DRAIN_DONE <= 1'b1;
            end else if (bus.POP_om) begin
                UNDERFLOW <= 1'b1;
            end
        end
    end

`ifdef RBUF_ADDR_CHECK_EN
    logic [AW-1:0] tag [DEPTH];
    logic [AW-1:0] raddr_d;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN || CLR_DP) begin
            for (int i = 0; i < DEPTH; i++)
                tag[i] <= '0;
            raddr_d       <= '0;
            ADDR_MISMATCH <= 1'b0;
        end else begin
            raddr_d       <= bus.RADDR_rb;
            ADDR_MISMATCH <= pop_ok && (bus.ODST_om != tag[cidx]);
            if (re_d)
                tag[widx] <= raddr_d;
        end
    end
`else
    logic unused_odst;
    assign unused_odst = ^bus.ODST_om;
`endif
endmodule

// File: tb/tb_psum_rbuffer.sv
// tb_psum_rbuffer: directed plus random stimulus for psum_rbuffer, checked
// every cycle against a timeline model of fetch, hold and drain.
module tb_psum_rbuffer;
    logic        clk = 0;
    logic        rstn = 0;
    logic        clr = 0, load = 0, pop = 0;
    logic [2:0]  rt = 0;
    logic [3:0]  base = 0, odst = 0;
    logic        fd, dd, uf, busy, mm;
    logic [63:0] mem [16];

    int n_chk = 0, n_fail = 0, cur = 0;

    psum_rbuffer_if #(.DW(64), .AW(4)) bus ();

    assign bus.POP_om  = pop;
    assign bus.ODST_om = odst;

    psum_rbuffer #(.DW(64), .AW(4), .DEPTH(4)) dut (
        .CLK(clk), .RSTN(rstn), .CLR_DP(clr), .ROW_TOTAL(rt),
        .LOAD_REQ(load), .BASE_ADDR(base), .FETCH_DONE(fd),
        .DRAIN_DONE(dd), .UNDERFLOW(uf), .BUSY(busy),
`ifdef RBUF_ADDR_CHECK_EN
        .ADDR_MISMATCH(mm),
`endif
        .bus(bus)
    );
`ifndef RBUF_ADDR_CHECK_EN
    assign mm = 1'b0;
`endif

    always #5 clk = ~clk;

    // Output-Memory: one-cycle read latency, garbage when not read
    always @(posedge clk)
        bus.RData_om <= bus.RE_rb ? mem[bus.RADDR_rb] : {$urandom, $urandom};

    // model state
    bit          m_busy, m_zp;
    int          m_t0, m_n, m_k;
    logic [3:0]  m_base;
    logic [63:0] m_rows [4];
    logic        e_re, e_fd, e_dd, e_uf, e_pv, e_mm, e_busy;
    logic [3:0]  e_ra;
    logic [63:0] e_psum;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cur, act, exp);
        end
    endtask

    task automatic model_clear();
        m_busy = 0; m_zp = 0; m_k = 0; m_n = 0; m_t0 = 0; m_base = 0;
        e_re = 0; e_fd = 0; e_dd = 0; e_uf = 0; e_pv = 0; e_mm = 0;
        e_busy = 0; e_ra = 0; e_psum = '0;
    endtask

    task automatic model_step();
        bit was_busy;
        int n;
        was_busy = m_busy;
        e_fd = 0; e_dd = 0; e_uf = 0; e_pv = 0; e_mm = 0;
        if (clr) begin
            m_busy = 0; m_zp = 0; e_psum = '0;
        end else begin
            if (m_zp) e_dd = 1;
            m_zp = 0;
            if (m_busy && cur == m_t0 + m_n + 1) e_fd = 1;
            if (pop) begin
                if (m_busy && cur >= m_t0 + m_n + 2) begin
                    e_psum = m_rows[m_k];
                    e_pv   = 1;
                    e_mm   = (odst != 4'(m_base + m_k));
                    m_k++;
                    if (m_k == m_n) begin e_dd = 1; m_busy = 0; end
                end else e_uf = 1;
            end
            if (load && !was_busy) begin
                n = (rt > 4) ? 4 : int'(rt);
                if (n == 0) begin
                    e_fd = 1; m_zp = 1;
                end else begin
                    m_busy = 1; m_t0 = cur; m_n = n; m_base = base; m_k = 0;
                    for (int i = 0; i < n; i++) m_rows[i] = mem[4'(base + i)];
                end
            end
        end
        e_busy = m_busy;
        e_re   = m_busy && (cur + 1 >= m_t0 + 1) && (cur + 1 <= m_t0 + m_n);
        e_ra   = e_re ? 4'(m_base + (cur - m_t0)) : 4'd0;
    endtask

    // advance one clock and compare every output with the model
    task automatic cyc();
        model_step();
        @(posedge clk); #1;
        cur++;
        chk("re", bus.RE_rb, e_re);
        chk("raddr", bus.RADDR_rb, e_ra);
        chk("fetch_done", fd, e_fd);
        chk("drain_done", dd, e_dd);
        chk("underflow", uf, e_uf);
        chk("busy", busy, e_busy);
        chk("pvalid", bus.PVALID_rb, e_pv);
        chk("psum", bus.PSUM_rb, e_psum);
`ifdef RBUF_ADDR_CHECK_EN
        chk("addr_mismatch", mm, e_mm);
`endif
    endtask

    task automatic idle_in();
        clr = 0; load = 0; pop = 0; rt = 0; base = 0; odst = 0;
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic check_zero(string nm);
        chk({nm, "_re"}, bus.RE_rb, 0);
        chk({nm, "_fd"}, fd, 0);
        chk({nm, "_dd"}, dd, 0);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_psum"}, bus.PSUM_rb, 0);
        chk({nm, "_pv"}, bus.PVALID_rb, 0);
    endtask

    initial begin
        logic [63:0] lit [4];
        logic [3:0]  ra [$];
        int          fd_at, cntr;

        for (int i = 0; i < 16; i++) mem[i] = {$urandom, $urandom};
        lit[0] = 64'h0000_000A_0000_00A0;
        lit[1] = 64'h0000_000B_0000_00B0;
        lit[2] = 64'h0000_000C_0000_00C0;
        lit[3] = 64'h0000_000D_0000_00D0;
        for (int i = 0; i < 4; i++) mem[4 + i] = lit[i];
        mem[14] = 64'h1414; mem[15] = 64'h1515; mem[0] = 64'h0F0F;
        mem[2]  = 64'h2222; mem[3]  = 64'h3333;

        idle_in(); model_clear();
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        chk("reset_uf", uf, 0);
        rstn = 1;

        // 1: base 4, four rows
        load = 1; rt = 4; base = 4;
        cyc(); idle_in();
        fd_at = -1;
        for (int k = 1; k <= 6; k++) begin
            if (bus.RE_rb) ra.push_back(bus.RADDR_rb);
            if (fd) fd_at = k;
            if (k < 6) cyc();
        end
        chk("t1_nreads", ra.size(), 4);
        for (int i = 0; i < ra.size(); i++) chk("t1_raddr", ra[i], 4 + i);
        chk("t1_fd_cycle", fd_at, 6);
        pop = 1;
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("t1_psum", bus.PSUM_rb, lit[k]);
        end
        chk("t1_drain", dd, 1);
        idle_in(); cyc();
        chk("t1_busy", busy, 0);
        chk("t1_psum_hold", bus.PSUM_rb, lit[3]);

        // 2: wrap 14,15,0
        ra.delete();
        load = 1; rt = 3; base = 14;
        cyc(); idle_in();
        for (int k = 0; k < 4; k++) begin
            if (bus.RE_rb) ra.push_back(bus.RADDR_rb);
            cyc();
        end
        chk("t2_nreads", ra.size(), 3);
        if (ra.size() == 3) begin
            chk("t2_raddr0", ra[0], 14);
            chk("t2_raddr1", ra[1], 15);
            chk("t2_raddr2", ra[2], 0);
        end
        pop = 1;
        cyc(); chk("t2_psum0", bus.PSUM_rb, 64'h1414);
        cyc(); chk("t2_psum1", bus.PSUM_rb, 64'h1515);
        cyc(); chk("t2_psum2", bus.PSUM_rb, 64'h0F0F);
        idle_in(); cyc();

        // 3: zero rows, then clamped seven rows
        load = 1; rt = 0; base = 5;
        cyc(); idle_in();
        chk("t3_fd", fd, 1);
        chk("t3_re", bus.RE_rb, 0);
        cyc();
        chk("t3_dd", dd, 1);
        chk("t3_busy", busy, 0);
        cntr = 0;
        load = 1; rt = 7; base = 9;
        for (int k = 0; k < 7; k++) begin
            cyc(); idle_in();
            if (bus.RE_rb) cntr++;
        end
        chk("t3_clamp_reads", cntr, 4);
        pop = 1; run(5); idle_in();

        // 4: pop during fetch, load while holding
        load = 1; rt = 2; base = 0;
        cyc(); idle_in();
        pop = 1; cyc(); pop = 0;
        chk("t4_uf", uf, 1);
        chk("t4_pv", bus.PVALID_rb, 0);
        run(2);
        pop = 1; cyc(); pop = 0;
        chk("t4_row0", bus.PSUM_rb, mem[0]);
        load = 1; rt = 1; base = 9; cyc(); idle_in();
        chk("t4_ignored_busy", busy, 1);
        chk("t4_ignored_re", bus.RE_rb, 0);
        pop = 1; cyc(); idle_in();
        chk("t4_row1", bus.PSUM_rb, mem[1]);
        chk("t4_dd", dd, 1);

        // 5: clear after two issues, then a normal fetch
        load = 1; rt = 4; base = 8;
        cyc(); idle_in();
        run(2);
        clr = 1; cyc(); clr = 0;
        chk("t5_busy", busy, 0);
        chk("t5_re", bus.RE_rb, 0);
        cntr = 0;
        for (int k = 0; k < 6; k++) begin cyc(); if (fd) cntr++; end
        chk("t5_no_fd", cntr, 0);
        load = 1; rt = 2; base = 3;
        cyc(); idle_in(); run(3);
        pop = 1; run(2); idle_in();
        chk("t5_psum", bus.PSUM_rb, lit[0]);

        // async reset mid-fetch
        load = 1; rt = 4; base = 0;
        cyc(); idle_in(); run(1);
        rstn = 0; #2;
        check_zero("rst_mid");
        model_clear();
        @(posedge clk); #1;
        cur++;
        rstn = 1;
        cntr = 0;
        for (int k = 0; k < 6; k++) begin cyc(); if (fd) cntr++; end
        chk("rst_no_fd", cntr, 0);

        // 6: destination check
        load = 1; rt = 2; base = 2;
        cyc(); idle_in(); run(3);
        pop = 1; odst = 3; cyc();
        chk("t6_psum0", bus.PSUM_rb, 64'h2222);
`ifdef RBUF_ADDR_CHECK_EN
        chk("t6_mm0", mm, 1);
`endif
        cyc(); idle_in();
        chk("t6_psum1", bus.PSUM_rb, 64'h3333);
`ifdef RBUF_ADDR_CHECK_EN
        chk("t6_mm1", mm, 0);
`endif
        cyc();

        // random
        for (int i = 0; i < 3000; i++) begin
            clr  = ($urandom_range(0, 99) == 0);
            load = ($urandom_range(0, 5) == 0);
            rt   = 3'($urandom);
            base = 4'($urandom);
            pop  = ($urandom_range(0, 2) == 0);
            odst = (m_busy && $urandom_range(0, 1) == 1) ?
                   4'(m_base + m_k) : 4'($urandom);
            cyc();
        end
        idle_in(); cyc();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
